mod2_seq_ctrl: RTL

- Frame sequencer for the second radix-2 FFT module stage, which is built from four parallel BF2I_4bundle butterflies followed by a fac8_0 reorder/twiddle network.
- Takes the upstream CBFP valid level and generates the shared butterfly enable, the load/compute phase select and the twiddle index.
- Tracks output-side valid through the butterfly delay line.
- Emits the downstream alert, frame-done pulse, frame count and a sticky frame-gap error.

---
 rtl/mod2_seq_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mod2_seq_ctrl.sv
// Frame sequencer for the second radix-2 FFT stage: drives the shared butterfly
// enable, load/compute select and twiddle index, and tracks output validity.
module mod2_seq_ctrl #(
    parameter int FRAME_CYC = 32,
    parameter int DEPTH     = 4,
    parameter int IW        = $clog2(FRAME_CYC)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          alert_cbfp1,
    input  logic          clr_err,
    output logic          bf_en,
    output logic          bf_sel,
    output logic [IW-1:0] tw_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          alert_mod20,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          err_gap,
    output logic          busy
);

    localparam int            DW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            SEL_BIT = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST    = IW'(FRAME_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    in_cnt;
    logic [IW-1:0]    in_cnt_nxt;
    logic [DW-1:0]    drain_cnt;
    logic [DW-1:0]    drain_cnt_nxt;
    logic [DEPTH-1:0] dl;
    logic             abort;

    assign bf_en      = alert_cbfp1;
    assign tw_idx     = in_cnt;
    assign bf_sel     = in_cnt[SEL_BIT];
    assign out_valid  = dl[DEPTH-1];
    assign frame_done = out_valid && (out_idx == LAST);
    assign busy       = (state != IDLE) || (|dl);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            in_cnt    <= in_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // A sample arriving while idle or draining is index 0 of a new frame.
    always_comb begin
        state_nxt     = state;
        in_cnt_nxt    = in_cnt;
        drain_cnt_nxt = drain_cnt;
        abort         = 1'b0;
        case (state)
            IDLE: begin
                if (alert_cbfp1) begin
                    state_nxt  = RUN;
                    in_cnt_nxt = IW'(1);
                end
            end
            RUN: begin
                if (alert_cbfp1) begin
                    if (in_cnt == LAST) begin
                        in_cnt_nxt    = '0;
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DW'(DEPTH - 1);
                    end else begin
                        in_cnt_nxt = in_cnt + IW'(1);
                    end
                end else begin
                    abort      = 1'b1;
                    in_cnt_nxt = '0;
                    state_nxt  = IDLE;
                end
            end
            DRAIN: begin
                if (alert_cbfp1) begin
                    state_nxt  = RUN;
                    in_cnt_nxt = IW'(1);
                end else if (drain_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt - DW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                in_cnt_nxt = '0;
            end
        endcase
    end

    // An abort flushes everything in flight, including a previous frame's tail.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl          <= '0;
            out_idx     <= '0;
            frame_cnt   <= '0;
            err_gap     <= 1'b0;
            alert_mod20 <= 1'b0;
        end else begin
            alert_mod20 <= out_valid;
            if (abort) begin
                dl      <= '0;
                out_idx <= '0;
            end else begin
                dl <= (dl << 1) | DEPTH'(alert_cbfp1);
                if (out_valid) begin
                    out_idx <= (out_idx == LAST) ? '0 : out_idx + IW'(1);
                end
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (abort) begin
                err_gap <= 1'b1;
            end else if (clr_err) begin
                err_gap <= 1'b0;
            end
        end
    end

endmodule
